core_mc: RTL and testbench

- Multi-cycle successor to the single-cycle NPC core top.
- Replaces the combinational fetch path with a request/grant/rvalid instruction-fetch handshake, so memory may stall arbitrarily.
- Register-file size, reset PC and counter width are parametrised.
- Exit/halt is reported through registered outputs rather than a simulation call, so the bench or a wrapper decides when to stop.
- Integrates fetch sequencing, decode, register file and ALU for the supported RV32I/E subset.

---
 rtl/core_mc.sv | 274 +++++++++++++++++++++++++++
 tb/tb_core_mc.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mc.sv
// core_mc: multi-cycle RV32I/E subset core.
//
// Each instruction is fetched over a request/grant/rvalid handshake and
// then decoded and executed in one EXEC cycle. Memory may stall for any
// number of cycles in FETCH (grant) or WAIT (rvalid).
//
// Ports:
//   clk, rst       core clock (rising edge), asynchronous active-high reset
//   ifetch_req     fetch request, high only in FETCH
//   ifetch_addr    fetch address (always the current pc)
//   ifetch_gnt     memory accepted the request this cycle
//   ifetch_rvalid  ifetch_rdata carries the fetched word this cycle
//   ifetch_rdata   fetched instruction word
//   halted         sticky stop flag
//   good_trap      stopped on EBREAK with a0 == 0
//   exit_code      a0 captured at EBREAK
//   illegal_inst   stopped on an illegal or misaligned instruction
//   retire         one-cycle pulse per completed instruction
//   retire_pc      pc of the retiring instruction
//   instret        retired-instruction counter, wraps
module core_mc #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              NR_REGS  = 32,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifetch_req,
    output logic [XLEN-1:0]  ifetch_addr,
    input  logic             ifetch_gnt,
    input  logic             ifetch_rvalid,
    input  logic [31:0]      ifetch_rdata,
    output logic             halted,
    output logic             good_trap,
    output logic [XLEN-1:0]  exit_code,
    output logic             illegal_inst,
    output logic             retire,
    output logic [XLEN-1:0]  retire_pc,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_EXEC,
        ST_HALT
    } state_t;

    state_t            state_reg, state_next;
    logic [XLEN-1:0]   pc_reg;
    logic [31:0]       ir_reg;
    logic [CNT_W-1:0]  instret_reg;
    logic              halted_reg;
    logic              good_trap_reg;
    logic              illegal_reg;
    logic [XLEN-1:0]   exit_code_reg;

    // Register file read view: 32 entries regardless of NR_REGS so any
    // 5-bit field indexes safely; x0 and unimplemented entries read 0.
    logic [XLEN-1:0]   rf [32];

    // Instruction fields
    logic [6:0]        opcode;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN-1:0]   imm_i, imm_u, imm_j;
    logic [XLEN-1:0]   rs1_val, rs2_val;

    // Decode results
    logic              legal;
    logic              use_rd, use_rs1, use_rs2;
    logic              is_jump, is_ebreak;
    logic              reg_oob, misaligned, fault;
    logic [XLEN-1:0]   wb_val, jump_tgt, pc_next_val;
    logic              exec_ok, wb_en;

    assign opcode = ir_reg[6:0];
    assign rd     = ir_reg[11:7];
    assign funct3 = ir_reg[14:12];
    assign rs1    = ir_reg[19:15];
    assign rs2    = ir_reg[24:20];
    assign funct7 = ir_reg[31:25];

    assign imm_i = {{20{ir_reg[31]}}, ir_reg[31:20]};
    assign imm_u = {ir_reg[31:12], 12'b0};
    assign imm_j = {{11{ir_reg[31]}}, ir_reg[31], ir_reg[19:12], ir_reg[20], ir_reg[30:21], 1'b0};

    assign rs1_val = rf[rs1];
    assign rs2_val = rf[rs2];

    always_comb begin
        legal     = 1'b0;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        is_jump   = 1'b0;
        is_ebreak = 1'b0;
        wb_val    = '0;
        jump_tgt  = '0;
        case (opcode)
            7'b0110111: begin // LUI
                legal  = 1'b1;
                use_rd = 1'b1;
                wb_val = imm_u;
            end
            7'b0010111: begin // AUIPC
                legal  = 1'b1;
                use_rd = 1'b1;
                wb_val = pc_reg + imm_u;
            end
            7'b1101111: begin // JAL
                legal    = 1'b1;
                use_rd   = 1'b1;
                is_jump  = 1'b1;
                jump_tgt = pc_reg + imm_j;
                wb_val   = pc_reg + XLEN'(4);
            end
            7'b1100111: begin // JALR
                if (funct3 == 3'b000) begin
                    legal    = 1'b1;
                    use_rd   = 1'b1;
                    use_rs1  = 1'b1;
                    is_jump  = 1'b1;
                    jump_tgt = (rs1_val + imm_i) & ~XLEN'(1);
                    wb_val   = pc_reg + XLEN'(4);
                end
            end
            7'b0010011: begin // ADDI
                if (funct3 == 3'b000) begin
                    legal   = 1'b1;
                    use_rd  = 1'b1;
                    use_rs1 = 1'b1;
                    wb_val  = rs1_val + imm_i;
                end
            end
            7'b0110011: begin // ADD / SUB
                if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
                    legal   = 1'b1;
                    use_rd  = 1'b1;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                    wb_val  = funct7[5] ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
                end
            end
            7'b1110011: begin // only the exact EBREAK encoding
                if (ir_reg == 32'h0010_0073) begin
                    legal     = 1'b1;
                    is_ebreak = 1'b1;
                end
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Register fields beyond the implemented file (RV32E) make the
    // instruction illegal, but only for fields the instruction actually uses.
    assign reg_oob = (use_rd  && int'(rd)  >= NR_REGS) ||
                     (use_rs1 && int'(rs1) >= NR_REGS) ||
                     (use_rs2 && int'(rs2) >= NR_REGS);
    assign misaligned  = is_jump && jump_tgt[1];
    assign fault       = !legal || reg_oob || misaligned;
    assign exec_ok     = (state_reg == ST_EXEC) && !fault;
    assign wb_en       = exec_ok && use_rd && (rd != 5'd0);
    assign pc_next_val = is_jump ? jump_tgt : (pc_reg + XLEN'(4));

    // Register file: real flops only for x1..x(NR_REGS-1)
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rf
            if (gi == 0 || gi >= NR_REGS) begin : g_zero
                assign rf[gi] = '0;
            end else begin : g_reg
                logic [XLEN-1:0] x_reg;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        x_reg <= '0;
                    end else if (wb_en && rd == 5'(gi)) begin
                        x_reg <= wb_val;
                    end
                end
                assign rf[gi] = x_reg;
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_next = state_reg;
        ifetch_req = 1'b0;
        retire     = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                ifetch_req = 1'b1;
                if (ifetch_gnt) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ifetch_rvalid) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                retire = !fault;
                if (fault || is_ebreak) begin
                    state_next = ST_HALT;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_HALT;
            end
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg        <= RESET_PC;
            ir_reg        <= '0;
            instret_reg   <= '0;
            halted_reg    <= 1'b0;
            good_trap_reg <= 1'b0;
            illegal_reg   <= 1'b0;
            exit_code_reg <= '0;
        end else begin
            // rvalid outside WAIT (e.g. left over from before a reset) is dropped
            if (state_reg == ST_WAIT && ifetch_rvalid) begin
                ir_reg <= ifetch_rdata;
            end
            // A faulting instruction leaves pc on the offending address
            if (exec_ok) begin
                pc_reg      <= pc_next_val;
                instret_reg <= instret_reg + CNT_W'(1);
            end
            if (state_reg == ST_EXEC) begin
                if (fault) begin
                    halted_reg  <= 1'b1;
                    illegal_reg <= 1'b1;
                end else if (is_ebreak) begin
                    halted_reg    <= 1'b1;
                    exit_code_reg <= rf[10];
                    good_trap_reg <= (rf[10] == '0);
                end
            end
        end
    end

    assign ifetch_addr  = pc_reg;
    assign retire_pc    = pc_reg;
    assign instret      = instret_reg;
    assign halted       = halted_reg;
    assign good_trap    = good_trap_reg;
    assign illegal_inst = illegal_reg;
    assign exit_code    = exit_code_reg;

endmodule

// File: tb/tb_core_mc.sv
// tb_core_mc: directed vector bench for core_mc.
// A small instruction memory answers fetches with a programmable grant
// delay and rvalid delay; a second core instance built as RV32E is fed a
// fixed word to exercise the register-range check.
module tb_core_mc;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // Main DUT (RV32I)
    logic        req, gnt, rvalid, halted, good, ill, retire;
    logic [31:0] addr, rdata, exit_code, retire_pc, instret;

    // RV32E DUT
    logic        req_e, gnt_e, rvalid_e, halted_e, good_e, ill_e, retire_e;
    logic [31:0] addr_e, rdata_e, exit_e, rpc_e, instret_e;

    core_mc #(.XLEN(32), .RESET_PC(RPC), .NR_REGS(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifetch_req(req), .ifetch_addr(addr), .ifetch_gnt(gnt),
        .ifetch_rvalid(rvalid), .ifetch_rdata(rdata),
        .halted(halted), .good_trap(good), .exit_code(exit_code),
        .illegal_inst(ill), .retire(retire), .retire_pc(retire_pc),
        .instret(instret)
    );

    core_mc #(.XLEN(32), .RESET_PC(RPC), .NR_REGS(16), .CNT_W(32)) dut_e (
        .clk(clk), .rst(rst),
        .ifetch_req(req_e), .ifetch_addr(addr_e), .ifetch_gnt(gnt_e),
        .ifetch_rvalid(rvalid_e), .ifetch_rdata(rdata_e),
        .halted(halted_e), .good_trap(good_e), .exit_code(exit_e),
        .illegal_inst(ill_e), .retire(retire_e), .retire_pc(rpc_e),
        .instret(instret_e)
    );

    // Memory model configuration
    logic [31:0] mem [16];
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    bit          flush_on_rst = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    // Results of the last run
    int          n_ret;
    int          n_ret_e;
    logic [31:0] ret_pcs [8];
    bit          timeout;
    bit          addr_ok;

    // Memory responder: drives at negedge, data captured at grant time.
    initial begin
        int          gcnt;
        int          rcnt;
        bit          pend;
        bit          pend_e;
        logic [31:0] lat;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        gnt_e = 1'b0; rvalid_e = 1'b0; rdata_e = 32'h0010_0813;
        gcnt = 0; rcnt = 0; pend = 1'b0; pend_e = 1'b0; lat = '0;
        forever begin
            @(negedge clk);
            gnt = 1'b0;
            rvalid = 1'b0;
            if (rst) begin
                gnt_e = 1'b0; rvalid_e = 1'b0; pend_e = 1'b0;
                gcnt = gnt_delay;
                if (flush_on_rst) pend = 1'b0;
            end else begin
                rvalid_e = pend_e;
                pend_e   = req_e;
                gnt_e    = req_e;
                if (pend) begin
                    if (rcnt == 0) begin
                        rvalid = 1'b1;
                        rdata  = lat;
                        pend   = 1'b0;
                    end else begin
                        rcnt--;
                    end
                end else if (req) begin
                    if (gcnt == 0) begin
                        gnt  = 1'b1;
                        pend = 1'b1;
                        rcnt = rv_delay;
                        lat  = mem[addr[5:2]];
                        gcnt = gnt_delay;
                    end else begin
                        gcnt--;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        n_ret_e = 0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // Run until halted or the cycle budget expires, logging retirements
    // and checking that ifetch_addr holds while a request waits for grant.
    task automatic run_prog(input int max_cyc);
        bit          prev_hold;
        logic [31:0] prev_addr;
        n_ret = 0; timeout = 1'b1; addr_ok = 1'b1;
        prev_hold = 1'b0; prev_addr = '0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            #1;
            if (prev_hold && addr !== prev_addr) addr_ok = 1'b0;
            prev_hold = req && !gnt;
            prev_addr = addr;
            if (retire) begin
                if (n_ret < 8) ret_pcs[n_ret] = retire_pc;
                n_ret++;
            end
            if (retire_e) n_ret_e++;
            if (halted) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    // Once halted the core must stay quiet.
    task automatic chk_quiet(input string nm);
        bit ok;
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (req || retire || !halted) ok = 1'b0;
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    typedef struct packed {
        logic [63:0]      nm;
        logic [0:5][31:0] prog;
        int               gd;
        int               rd;
        int               nret;
        logic [0:4][31:0] pcs;
        logic [31:0]      exp_instret;
        logic [31:0]      exp_exit;
        bit               exp_good;
        bit               exp_ill;
        bit               chk_pc;
        logic [31:0]      exp_pc;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    initial begin : main
        bit got;
        vecs[0] = '{"gtrap",  '{32'h00500513, 32'h00000533, 32'h00100073, 0, 0, 0}, 0, 0, 3,
                    '{RPC, RPC+4, RPC+8, 0, 0}, 3, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{"stall",  '{32'h00500513, 32'h00100073, 0, 0, 0, 0}, 4, 2, 2,
                    '{RPC, RPC+4, 0, 0, 0}, 2, 32'h5, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{"jal_x0", '{32'h008000EF, 32'h00000000, 32'h00700013, 32'h00000533, 32'h00100073, 0}, 0, 0, 4,
                    '{RPC, RPC+8, RPC+12, RPC+16, 0}, 4, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{"jal_ra", '{32'h008000EF, 32'h00000000, 32'h00008533, 32'h00100073, 0, 0}, 1, 1, 3,
                    '{RPC, RPC+8, RPC+12, 0, 0}, 3, 32'h8000_0004, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{"illegal", '{32'h00000000, 0, 0, 0, 0, 0}, 0, 0, 0,
                    '{0, 0, 0, 0, 0}, 0, 32'h0, 1'b0, 1'b1, 1'b1, RPC};
        vecs[5] = '{"lui",    '{32'h12345537, 32'h00100073, 0, 0, 0, 0}, 0, 0, 2,
                    '{RPC, RPC+4, 0, 0, 0}, 2, 32'h1234_5000, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{"jalrmis", '{32'h00000297, 32'h006280E7, 0, 0, 0, 0}, 0, 0, 1,
                    '{RPC, 0, 0, 0, 0}, 1, 32'h0, 1'b0, 1'b1, 1'b1, RPC+4};
        vecs[7] = '{"jalrb0", '{32'h00000297, 32'h00D28067, 32'h00000000, 32'h00100073, 0, 0}, 0, 1, 3,
                    '{RPC, RPC+4, RPC+12, 0, 0}, 3, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[8] = '{"sub",    '{32'h00500513, 32'h00700593, 32'h40B50533, 32'h00100073, 0, 0}, 2, 1, 4,
                    '{RPC, RPC+4, RPC+8, RPC+12, 0}, 4, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 32'h0};

        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset values
        do_reset();
        chk("rst_req",     32'(req),       32'd1);
        chk("rst_addr",    addr,           RPC);
        chk("rst_instret", instret,        32'd0);
        chk("rst_halted",  32'(halted),    32'd0);
        chk("rst_flags",   {29'd0, good, ill, retire}, 32'd0);
        chk("rst_exit",    exit_code,      32'd0);

        // Table-driven programs
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < 16; i++) mem[i] = (i < 6) ? vecs[v].prog[i] : 32'h0;
            gnt_delay = vecs[v].gd;
            rv_delay  = vecs[v].rd;
            do_reset();
            run_prog(300);
            $display("vec %0d %0s: retired %0d instret %0d exit 0x%08h good %0d ill %0d",
                     v, vecs[v].nm, n_ret, instret, exit_code, good, ill);
            chk($sformatf("v%0d_halt", v), 32'(timeout), 32'd0);
            chk($sformatf("v%0d_nret", v), 32'(n_ret), 32'(vecs[v].nret));
            for (int k = 0; k < vecs[v].nret && k < 5 && k < n_ret; k++)
                chk($sformatf("v%0d_pc%0d", v, k), ret_pcs[k], vecs[v].pcs[k]);
            chk($sformatf("v%0d_instret", v), instret, vecs[v].exp_instret);
            chk($sformatf("v%0d_exit", v), exit_code, vecs[v].exp_exit);
            chk($sformatf("v%0d_good", v), 32'(good), 32'(vecs[v].exp_good));
            chk($sformatf("v%0d_ill", v), 32'(ill), 32'(vecs[v].exp_ill));
            chk($sformatf("v%0d_addr_stable", v), 32'(addr_ok), 32'd1);
            if (vecs[v].chk_pc) chk($sformatf("v%0d_fpc", v), addr, vecs[v].exp_pc);
            chk_quiet($sformatf("v%0d_quiet", v));
            if (v == 0) begin
                // RV32E core was fed addi x16,x0,1 since reset
                chk("e_halted",  32'(halted_e), 32'd1);
                chk("e_ill",     32'(ill_e),    32'd1);
                chk("e_nret",    32'(n_ret_e),  32'd0);
                chk("e_instret", instret_e,     32'd0);
                chk("e_pc",      addr_e,        RPC);
            end
        end

        // Asynchronous reset while a fetch is in flight; the stale rvalid
        // (an illegal word) lands after release and must be ignored.
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[1]    = 32'h0010_0073;
        gnt_delay = 0;
        rv_delay  = 4;
        do_reset();
        flush_on_rst = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            #1;
            if (gnt) got = 1'b1;
        end
        chk("arst_gnt_seen", 32'(got), 32'd1);
        mem[0] = 32'h0050_0513;
        @(negedge clk);
        #1;
        chk("arst_wait_req", 32'(req), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_req_now", 32'(req), 32'd1);
        chk("arst_addr_now", addr, RPC);
        @(negedge clk);
        #1 rst = 1'b0;
        n_ret_e = 0;
        run_prog(300);
        flush_on_rst = 1'b1;
        $display("arst: retired %0d instret %0d exit 0x%08h ill %0d", n_ret, instret, exit_code, ill);
        chk("arst_halt", 32'(timeout), 32'd0);
        chk("arst_ill", 32'(ill), 32'd0);
        chk("arst_nret", 32'(n_ret), 32'd2);
        chk("arst_exit", exit_code, 32'd5);
        chk("arst_instret", instret, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
